ifmaps_preload_ctrl: RTL and testbench
======================================

// Module: ifmaps_preload_ctrl
// PURPOSE
//  Sequencer for the ifmaps preload FIFO. Accepts a per-tile config (input channels, vector count).
//  Throttles the 32-bit AXIS ifmaps stream into the preload FIFO (load strobe).
//  Issues MAC_read pops to the MAC array only for fully written 5*MAC_NUM vectors.
//  Sits between the AXIS slave, the preload FIFO and the MAC array scheduler.
// PARAMETERS
//  C_S_AXIS_TDATA_WIDTH  32   AXIS data width; low 30 bits carry 6 x 5-bit channels
//  MAC_NUM               256  max channels per vector
//  FIFO_DEPTH            4    preload FIFO depth in vectors
//  CH_PER_WORD           6    channels packed per AXIS word
//  VEC_CNT_W             16   width of vector counters
// PORTS
//  clk                  in   1          clock
//  rst                  in   1          asynchronous reset, active-high
//  cfg_valid            in   1          config handshake valid
//  cfg_ready            out  1          high only in IDLE
//  cfg_channel_size     in   12         input channels per vector (1..MAC_NUM)
//  cfg_vector_num       in   VEC_CNT_W  vectors in this tile (>=1)
//  abort                in   1          synchronous abort to IDLE
//  s_axis_tvalid        in   1          AXIS word valid
//  s_axis_tready        out  1          AXIS word accepted
//  s_axis_tlast         in   1          last word of tile
//  load_ifmaps_preload  out  1          write strobe into preload FIFO
//  fifo_full            in   1          preload FIFO full
//  fifo_empty           in   1          preload FIFO empty
//  mac_ready            in   1          MAC array can take a vector this cycle
//  mac_read             out  1          pop one vector to MAC array
//  busy                 out  1          state != IDLE
//  done                 out  1          1-cycle pulse, tile fully consumed
//  err_cfg              out  1          1-cycle pulse, config rejected
//  err_tlast            out  1          sticky until next accepted config
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0. Outputs: cfg_ready=1; all other outputs 0.
//  FSM states: IDLE, CONFIG, RUN, DRAIN, DONE.
//  IDLE -> CONFIG on cfg_valid & cfg_ready.
//    Reject (err_cfg pulse, stay IDLE) if channel_size==0, channel_size>MAC_NUM, or vector_num==0.
//  CONFIG (1 cycle): register words_per_vec = (channel_size+5)/6, 12-bit.
//    Clear counters wr_word, vec_loaded, vec_read and err_tlast. Go to RUN.
//  RUN: s_axis_tready = ~fifo_full & (vec_loaded < vector_num).
//    load_ifmaps_preload = s_axis_tvalid & s_axis_tready (combinational, same cycle).
//    On each load: wr_word increments.
//    At wr_word==words_per_vec-1: wr_word wraps to 0 and vec_loaded increments.
//  Expected tlast is the last word of the last vector. tlast on any other word, or missing
//    on that word, sets err_tlast. Flow is unchanged.
//  mac_read = ~fifo_empty & mac_ready & (vec_loaded > vec_read); vec_read increments on each pop.
//    A vector completing and a pop in the same cycle update both counters independently.
//  RUN -> DRAIN when vec_loaded==vector_num.
//    DRAIN keeps popping; s_axis_tready=0.
//  DRAIN -> DONE when vec_read==vector_num after the pop.
//    DONE: done=1 for one cycle, then IDLE.
//  Latency: first mac_read no earlier than 1 cycle after the last word of vector 0 is loaded.
//  fifo_full mid-vector: tready drops; wr_word holds; resumes without loss.
//  abort (any non-IDLE state): next cycle IDLE. Counters clear; tready=0 and mac_read=0 that cycle.
//    FIFO contents are not flushed; the owner must assert rst before reuse.
//  Async rst mid-tile: immediate return to reset values.
//  Counter widths saturate-free: vector_num bounds all counts; no wrap within a tile.
// STRUCTURE
//  Package ifmaps_pkg holds:
//    CH_PER_WORD and the 5-bit channel width;
//    the state encoding localparams;
//    the ceil_div(ch, CH_PER_WORD) function, shared with axis_ifmaps_preload.
//  Single flat module; no sub-module needed (counters + FSM in one file).
// TESTING
//  1) ch=256, vec=1, mac_ready=1: 43 loads, then one mac_read. done pulses; err_tlast=0.
//  2) ch=12, vec=8, FIFO_DEPTH=4, fifo_full modelled, mac_ready=0 until 8 loads:
//     tready drops at full; all 8 pops occur; done pulses.
//  3) ch=7, vec=3: 2 words per vector. tlast on word 4 -> err_tlast=1; tile still completes.
//  4) cfg ch=0, then ch=300: err_cfg pulses each time; cfg_ready stays 1; busy stays 0.
//  5) ch=18, vec=4, abort asserted after 5 loads: next cycle busy=0, tready=0, mac_read=0.
//  6) Same-cycle vector complete and mac_read (ch=6, vec=4, mac_ready=1):
//     vec_loaded-vec_read never negative; exactly 4 pops.

Source files
------------

// File: rtl/ifmaps_preload_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the ifmaps preload path.
//   C_S_AXIS_TDATA_WIDTH : AXIS word width (low 30 bits = 6 x 5-bit channels)
//   CH_PER_WORD/CH_WIDTH : channel packing inside one AXIS word
//   MAC_NUM              : max channels per vector
//   FIFO_DEPTH           : preload FIFO depth in vectors
//   VEC_CNT_W/CFG_CH_W   : counter and config field widths
package ifmaps_preload_ctrl_pkg;

    localparam int unsigned C_S_AXIS_TDATA_WIDTH = 32;
    localparam int unsigned CH_WIDTH             = 5;
    localparam int unsigned CH_PER_WORD          = 6;
    localparam int unsigned MAC_NUM              = 256;
    localparam int unsigned FIFO_DEPTH           = 4;
    localparam int unsigned VEC_CNT_W            = 16;
    localparam int unsigned CFG_CH_W             = 12;

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Words needed to carry ch channels; one extra bit so the +5 cannot overflow.
    function automatic logic [CFG_CH_W-1:0] ceil_div(input logic [CFG_CH_W-1:0] ch);
        logic [CFG_CH_W:0] sum;
        sum = {1'b0, ch} + (CFG_CH_W+1)'(CH_PER_WORD - 1);
        return CFG_CH_W'(sum / (CFG_CH_W+1)'(CH_PER_WORD));
    endfunction

endpackage

// File: rtl/ifmaps_preload_ctrl_if.sv
// Handshake/bus bundle of the ifmaps preload sequencer.
//   cfg_*            : per-tile config handshake (channel size, vector count)
//   abort            : synchronous abort back to idle
//   s_axis_*         : AXIS valid/ready/last of the ifmaps stream
//   load/fifo_*      : preload FIFO write strobe and status
//   mac_ready/read   : vector pop handshake toward the MAC array
//   busy/done/err_*  : status
// slave = sequencer side, master = environment side.
interface ifmaps_preload_ctrl_if;
    import ifmaps_preload_ctrl_pkg::*;

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CFG_CH_W-1:0]  cfg_channel_size;
    logic [VEC_CNT_W-1:0] cfg_vector_num;
    logic                 abort;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic                 load_ifmaps_preload;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 mac_ready;
    logic                 mac_read;
    logic                 busy;
    logic                 done;
    logic                 err_cfg;
    logic                 err_tlast;

    modport slave (
        input  cfg_valid, cfg_channel_size, cfg_vector_num, abort,
        input  s_axis_tvalid, s_axis_tlast, fifo_full, fifo_empty, mac_ready,
        output cfg_ready, s_axis_tready, load_ifmaps_preload, mac_read,
        output busy, done, err_cfg, err_tlast
    );

    modport master (
        output cfg_valid, cfg_channel_size, cfg_vector_num, abort,
        output s_axis_tvalid, s_axis_tlast, fifo_full, fifo_empty, mac_ready,
        input  cfg_ready, s_axis_tready, load_ifmaps_preload, mac_read,
        input  busy, done, err_cfg, err_tlast
    );

endinterface

// File: rtl/ifmaps_preload_ctrl.sv
// Sequencer for the ifmaps preload FIFO.
// Takes a per-tile config, throttles the AXIS ifmaps stream into the preload FIFO
// (load strobe), and pops only fully written vectors toward the MAC array.
//   clk : clock
//   rst : asynchronous reset, active-high
//   bus : ifmaps_preload_ctrl_if.slave (config, AXIS, FIFO, MAC and status signals)
module ifmaps_preload_ctrl
    import ifmaps_preload_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ifmaps_preload_ctrl_if.slave  bus
);

    state_e               state_q;
    logic [CFG_CH_W-1:0]  ch_q;
    logic [CFG_CH_W-1:0]  wpv_q;
    logic [CFG_CH_W-1:0]  wr_word_q;
    logic [VEC_CNT_W-1:0] vec_num_q;
    logic [VEC_CNT_W-1:0] vec_loaded_q;
    logic [VEC_CNT_W-1:0] vec_read_q;
    logic                 err_cfg_q;
    logic                 err_tlast_q;

    logic                 tready;
    logic                 load;
    logic                 pop;
    logic                 vec_end;
    logic                 exp_last;
    logic                 cfg_ok;
    logic [VEC_CNT_W-1:0] vec_read_nxt;

    always_comb begin
        cfg_ok = (bus.cfg_channel_size != '0) &&
                 (bus.cfg_channel_size <= CFG_CH_W'(MAC_NUM)) &&
                 (bus.cfg_vector_num != '0);
        // abort blocks both strobes in the cycle it is seen
        tready = (state_q == StRun) && !bus.abort && !bus.fifo_full &&
                 (vec_loaded_q < vec_num_q);
        load   = bus.s_axis_tvalid && tready;
        pop    = ((state_q == StRun) || (state_q == StDrain)) && !bus.abort &&
                 !bus.fifo_empty && bus.mac_ready && (vec_loaded_q > vec_read_q);
        vec_end      = load && (wr_word_q == wpv_q - CFG_CH_W'(1));
        exp_last     = vec_end && (vec_loaded_q == vec_num_q - VEC_CNT_W'(1));
        vec_read_nxt = vec_read_q + VEC_CNT_W'(pop);
    end

    assign bus.cfg_ready           = (state_q == StIdle);
    assign bus.busy                = (state_q != StIdle);
    assign bus.done                = (state_q == StDone);
    assign bus.s_axis_tready       = tready;
    assign bus.load_ifmaps_preload = load;
    assign bus.mac_read            = pop;
    assign bus.err_cfg             = err_cfg_q;
    assign bus.err_tlast           = err_tlast_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            ch_q         <= '0;
            wpv_q        <= '0;
            wr_word_q    <= '0;
            vec_num_q    <= '0;
            vec_loaded_q <= '0;
            vec_read_q   <= '0;
            err_cfg_q    <= 1'b0;
            err_tlast_q  <= 1'b0;
        end else begin
            err_cfg_q <= 1'b0;
            if (bus.abort && (state_q != StIdle)) begin
                // FIFO contents are left alone; only the sequencer returns to idle
                state_q      <= StIdle;
                wr_word_q    <= '0;
                vec_loaded_q <= '0;
                vec_read_q   <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus.cfg_valid) begin
                            if (cfg_ok) begin
                                ch_q      <= bus.cfg_channel_size;
                                vec_num_q <= bus.cfg_vector_num;
                                state_q   <= StConfig;
                            end else begin
                                err_cfg_q <= 1'b1;
                            end
                        end
                    end
                    StConfig: begin
                        wpv_q        <= ceil_div(ch_q);
                        wr_word_q    <= '0;
                        vec_loaded_q <= '0;
                        vec_read_q   <= '0;
                        err_tlast_q  <= 1'b0;
                        state_q      <= StRun;
                    end
                    StRun, StDrain: begin
                        if (load) begin
                            if (vec_end) begin
                                wr_word_q    <= '0;
                                vec_loaded_q <= vec_loaded_q + VEC_CNT_W'(1);
                            end else begin
                                wr_word_q <= wr_word_q + CFG_CH_W'(1);
                            end
                            // tlast must mark exactly the final word of the tile
                            if (bus.s_axis_tlast != exp_last) begin
                                err_tlast_q <= 1'b1;
                            end
                        end
                        vec_read_q <= vec_read_nxt;
                        if ((state_q == StRun) && (vec_loaded_q == vec_num_q)) begin
                            state_q <= StDrain;
                        end
                        if ((state_q == StDrain) && (vec_read_nxt == vec_num_q)) begin
                            state_q <= StDone;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifmaps_preload_ctrl.sv
module tb_ifmaps_preload_ctrl;
    import ifmaps_preload_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifmaps_preload_ctrl_if bus ();

    ifmaps_preload_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (tile-level word/vector counts) ----------------
    typedef enum int {MIdle, MCfg, MRun, MDrain, MDone} mph_e;
    mph_e mph = MIdle;
    int m_ch = 0, m_n = 0, m_wpv = 1, m_loads = 0, m_pops = 0;
    int m_err_cfg = 0, m_err_tlast = 0;
    int e_tready, e_load, e_pop, m_total, vec_before;
    int obs_loads = 0, obs_pops = 0, obs_done = 0, obs_err_cfg = 0, obs_busy = 0, obs_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            mph = MIdle; m_loads = 0; m_pops = 0; m_err_cfg = 0; m_err_tlast = 0; m_wpv = 1;
            m_n = 0;
        end
        m_total  = m_wpv * m_n;
        e_tready = int'(mph == MRun && !bus.abort && !bus.fifo_full && m_loads < m_total);
        e_load   = int'(e_tready != 0 && bus.s_axis_tvalid);
        e_pop    = int'((mph == MRun || mph == MDrain) && !bus.abort && !bus.fifo_empty &&
                        bus.mac_ready && (m_loads / m_wpv > m_pops));

        chk("cfg_ready", int'(bus.cfg_ready), int'(mph == MIdle));
        chk("busy",      int'(bus.busy),      int'(mph != MIdle));
        chk("done",      int'(bus.done),      int'(mph == MDone));
        chk("err_cfg",   int'(bus.err_cfg),   m_err_cfg);
        chk("err_tlast", int'(bus.err_tlast), m_err_tlast);
        chk("tready",    int'(bus.s_axis_tready), e_tready);
        chk("load",      int'(bus.load_ifmaps_preload), e_load);
        chk("mac_read",  int'(bus.mac_read),  e_pop);

        obs_loads   += int'(bus.load_ifmaps_preload);
        obs_pops    += int'(bus.mac_read);
        obs_done    += int'(bus.done);
        obs_err_cfg += int'(bus.err_cfg);
        obs_busy    += int'(bus.busy);
        obs_stall   += int'(bus.busy && bus.fifo_full && bus.s_axis_tvalid && !bus.s_axis_tready);

        if (!rst) begin
            vec_before = m_loads / m_wpv;
            m_err_cfg  = 0;
            if (bus.abort && mph != MIdle) begin
                mph = MIdle; m_loads = 0; m_pops = 0;
            end else begin
                case (mph)
                    MIdle: if (bus.cfg_valid) begin
                        if (bus.cfg_channel_size >= 1 && bus.cfg_channel_size <= 256 &&
                            bus.cfg_vector_num >= 1) begin
                            m_ch = int'(bus.cfg_channel_size);
                            m_n  = int'(bus.cfg_vector_num);
                            mph  = MCfg;
                        end else begin
                            m_err_cfg = 1;
                        end
                    end
                    MCfg: begin
                        m_wpv = (m_ch + 5) / 6;
                        m_loads = 0; m_pops = 0; m_err_tlast = 0;
                        mph = MRun;
                    end
                    MRun, MDrain: begin
                        if (e_load != 0) begin
                            if (int'(bus.s_axis_tlast) != int'(m_loads == m_total - 1))
                                m_err_tlast = 1;
                            m_loads++;
                        end
                        if (e_pop != 0) m_pops++;
                        if (mph == MRun && vec_before == m_n) mph = MDrain;
                        else if (mph == MDrain && m_pops == m_n) mph = MDone;
                    end
                    MDone: mph = MIdle;
                    default: mph = MIdle;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.cfg_valid = 0; bus.cfg_channel_size = '0; bus.cfg_vector_num = '0; bus.abort = 0;
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.fifo_full = 0; bus.fifo_empty = 1;
        bus.mac_ready = 0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1; idle_inputs();
        repeat (2) @(posedge clk);
        #1; rst = 0;
    endtask

    // Called at posedge+1; leaves cfg_valid low at posedge+1 of the next cycle.
    task automatic send_cfg(input int ch, input int vn);
        bus.cfg_valid = 1; bus.cfg_channel_size = CFG_CH_W'(ch);
        bus.cfg_vector_num = VEC_CNT_W'(vn);
        @(posedge clk); #1;
        bus.cfg_valid = 0;
    endtask

    // rdy_mode: 0 random, 1 always, 2 only after 8 loads. status: 1 done, 2 abort, 3 rst.
    task automatic run_tile(input int ch, input int vn, input int rdy_mode, input int noise,
                            input int bad_word, input int abort_at, input int rst_at,
                            output int status);
        int wpv, total, sent, fill;
        wpv = (ch + 5) / 6; total = wpv * vn; sent = 0; fill = 0; status = 0;
        @(posedge clk); #1;
        send_cfg(ch, vn);
        for (int cyc = 0; cyc < 5000; cyc++) begin
            bus.s_axis_tvalid = (sent < total) && ($urandom_range(0, 3) != 0);
            bus.s_axis_tlast  = (bad_word >= 0) ? (sent == bad_word) : (sent == total - 1);
            case (rdy_mode)
                0: bus.mac_ready = $urandom_range(0, 1) == 1;
                1: bus.mac_ready = 1;
                default: bus.mac_ready = (sent >= 8);
            endcase
            bus.fifo_full  = (fill >= int'(FIFO_DEPTH) * wpv) ||
                             (noise != 0 && $urandom_range(0, 5) == 0);
            bus.fifo_empty = (fill == 0) || (noise != 0 && $urandom_range(0, 5) == 0);
            bus.abort      = (abort_at >= 0 && sent == abort_at);
            if (rst_at >= 0 && sent == rst_at) begin
                rst = 1; status = 3;
            end
            @(negedge clk);
            if (status == 3) break;
            if (bus.load_ifmaps_preload) begin sent++; fill++; end
            if (bus.mac_read) fill -= wpv;
            if (bus.done) begin status = 1; break; end
            if (bus.abort) begin status = 2; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    int st, l0, p0, d0, s0, c0, b0, ch, vn, bw;

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1; rst = 0;

        // 1) one 256-channel vector: 43 words then one pop
        l0 = obs_loads; p0 = obs_pops; d0 = obs_done;
        run_tile(256, 1, 1, 0, -1, -1, -1, st);
        chk("t1_status", st, 1);
        chk("t1_loads", obs_loads - l0, 43);
        chk("t1_pops", obs_pops - p0, 1);
        chk("t1_done", obs_done - d0, 1);
        chk("t1_err_tlast", int'(bus.err_tlast), 0);

        // 2) FIFO fills with mac_ready held low; backpressure then full drain
        l0 = obs_loads; p0 = obs_pops; d0 = obs_done; s0 = obs_stall;
        run_tile(12, 8, 2, 0, -1, -1, -1, st);
        chk("t2_status", st, 1);
        chk("t2_loads", obs_loads - l0, 16);
        chk("t2_pops", obs_pops - p0, 8);
        chk("t2_done", obs_done - d0, 1);
        chk("t2_stall_seen", int'(obs_stall - s0 > 0), 1);

        // 3) tlast on word 4 instead of word 6: error but tile completes
        p0 = obs_pops; d0 = obs_done;
        run_tile(7, 3, 0, 0, 3, -1, -1, st);
        chk("t3_status", st, 1);
        chk("t3_err_tlast", int'(bus.err_tlast), 1);
        chk("t3_pops", obs_pops - p0, 3);
        chk("t3_done", obs_done - d0, 1);

        // 4) rejected configs
        c0 = obs_err_cfg; b0 = obs_busy;
        @(posedge clk); #1; send_cfg(0, 2);
        @(posedge clk); #1; send_cfg(300, 2);
        @(posedge clk); #1; send_cfg(5, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_err_cfg", obs_err_cfg - c0, 3);
        chk("t4_busy", obs_busy - b0, 0);
        chk("t4_err_tlast_kept", int'(bus.err_tlast), 1);

        // 5) abort after 5 loads
        l0 = obs_loads;
        run_tile(18, 4, 0, 0, -1, 5, -1, st);
        chk("t5_status", st, 2);
        chk("t5_loads", obs_loads - l0, 5);
        @(negedge clk);
        chk("t5_busy", int'(bus.busy), 0);
        chk("t5_tready", int'(bus.s_axis_tready), 0);
        chk("t5_mac_read", int'(bus.mac_read), 0);
        pulse_rst();

        // 6) one word per vector, loads and pops overlap
        l0 = obs_loads; p0 = obs_pops; d0 = obs_done;
        run_tile(6, 4, 1, 0, -1, -1, -1, st);
        chk("t6_status", st, 1);
        chk("t6_loads", obs_loads - l0, 4);
        chk("t6_pops", obs_pops - p0, 4);
        chk("t6_done", obs_done - d0, 1);

        // 7) random tiles with noisy FIFO status
        for (int t = 0; t < 6; t++) begin
            ch = $urandom_range(1, 256); vn = $urandom_range(1, 5);
            bw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            p0 = obs_pops;
            run_tile(ch, vn, 0, 1, bw, -1, -1, st);
            chk("t7_status", st, 1);
            chk("t7_pops", obs_pops - p0, vn);
        end

        // 8) asynchronous reset in the middle of a tile
        run_tile(30, 3, 0, 0, -1, -1, 4, st);
        chk("t8_status", st, 3);
        chk("t8_cfg_ready", int'(bus.cfg_ready), 1);
        chk("t8_busy", int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        #1; rst = 0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
